act_pingpong_buf: RTL and testbench

ACT_PINGPONG_BUF -- requirements
Module: act_pingpong_buf

---
 rtl/act_pingpong_buf.sv | 112 +++++++++++
 tb/tb_act_pingpong_buf.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/act_pingpong_buf.sv
// rtl/act_pingpong_buf.sv - two-bank ping-pong activation buffer
// Writer fills one bank while the reader drains the other; commit/release hand banks across.
module act_pingpong_buf #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_commit,
  output logic              wr_ready,
  output logic              wr_drop,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_release,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   rd_len,
  output logic [1:0]        bank_full
);

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

  // Both banks share one array; the bank select is the address MSB.
  logic [DATA_W-1:0] mem_q [2*DEPTH];

  logic [1:0]        bank_full_q, bank_full_d;
  logic              wsel_q, wsel_d;
  logic              rsel_q, rsel_d;
  logic [ADDR_W:0]   wcnt_q [2];
  logic [ADDR_W:0]   wcnt_d [2];
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              wr_drop_q, wr_drop_d;

  logic wr_acc, cm_acc, rd_acc, rel_acc;

  assign wr_ready  = !bank_full_q[wsel_q];
  assign rd_ready  = bank_full_q[rsel_q];
  assign wr_acc    = wr_en && wr_ready;
  assign cm_acc    = wr_commit && wr_ready;
  assign rd_acc    = rd_en && rd_ready;
  assign rel_acc   = rd_release && rd_ready;

  assign wr_drop   = wr_drop_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign bank_full = bank_full_q;
  assign rd_len    = rd_ready ? wcnt_q[rsel_q] : '0;

  // Accepted write and release always address different banks, so their count updates never collide.
  always_comb begin
    bank_full_d = bank_full_q;
    wsel_d      = wsel_q;
    rsel_d      = rsel_q;
    wcnt_d      = wcnt_q;
    rd_valid_d  = rd_acc;
    rd_data_d   = rd_data_q;
    wr_drop_d   = (wr_en || wr_commit) && !wr_ready;

    if (wr_acc && (wcnt_q[wsel_q] != CNT_MAX)) begin
      wcnt_d[wsel_q] = wcnt_q[wsel_q] + CNT_ONE;
    end
    if (cm_acc) begin
      bank_full_d[wsel_q] = 1'b1;
      wsel_d              = !wsel_q;
    end
    if (rd_acc) begin
      rd_data_d = mem_q[{rsel_q, rd_addr}];
    end
    if (rel_acc) begin
      bank_full_d[rsel_q] = 1'b0;
      wcnt_d[rsel_q]      = '0;
      rsel_d              = !rsel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full_q <= 2'b00;
      wsel_q      <= 1'b0;
      rsel_q      <= 1'b0;
      wcnt_q[0]   <= '0;
      wcnt_q[1]   <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      wr_drop_q   <= 1'b0;
    end else begin
      bank_full_q <= bank_full_d;
      wsel_q      <= wsel_d;
      rsel_q      <= rsel_d;
      wcnt_q[0]   <= wcnt_d[0];
      wcnt_q[1]   <= wcnt_d[1];
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      wr_drop_q   <= wr_drop_d;
    end
  end

  // Storage is not reset, but reset still suppresses a same-cycle write.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[{wsel_q, wr_addr}] <= wr_data;
    end
  end

endmodule

// File: tb/tb_act_pingpong_buf.sv
// tb/tb_act_pingpong_buf.sv - self-checking bench for act_pingpong_buf
// Reference model: a FIFO of committed banks plus per-bank storage arrays.
module tb_act_pingpong_buf;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst, wr_en, wr_commit, rd_en, rd_release;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready, wr_drop, rd_ready, rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   rd_len;
  logic [1:0]        bank_full;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  act_pingpong_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_commit(wr_commit),
    .wr_ready(wr_ready), .wr_drop(wr_drop),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release),
    .rd_ready(rd_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_len(rd_len), .bank_full(bank_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bank;
    int len;
  } ent_t;

  ent_t              m_q[$];
  int                m_wb, m_cnt;
  logic [DATA_W-1:0] m_mem [2][DEPTH];
  bit                m_kn  [2][DEPTH];
  logic [DATA_W-1:0] m_rd;
  bit                m_rdk, m_rv, m_drop;

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++) m_kn[b][a] = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_wb = 0; m_cnt = 0;
      m_rv = 1'b0; m_rd = '0; m_rdk = 1'b1; m_drop = 1'b0;
    end else begin
      bit wr_ok, rd_ok;
      wr_ok  = (m_q.size() < 2);
      rd_ok  = (m_q.size() > 0);
      m_drop = (wr_en || wr_commit) && !wr_ok;
      m_rv   = rd_en && rd_ok;
      if (m_rv) begin
        m_rd  = m_mem[m_q[0].bank][rd_addr];
        m_rdk = m_kn[m_q[0].bank][rd_addr];
      end
      if (wr_en && wr_ok) begin
        m_mem[m_wb][wr_addr] = wr_data;
        m_kn[m_wb][wr_addr]  = 1'b1;
        if (m_cnt < DEPTH) m_cnt++;
      end
      if (rd_release && rd_ok) void'(m_q.pop_front());
      if (wr_commit && wr_ok) begin
        m_q.push_back('{bank: m_wb, len: m_cnt});
        m_wb  = 1 - m_wb;
        m_cnt = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [1:0] exp_full;
      exp_full = 2'b00;
      foreach (m_q[i]) exp_full[m_q[i].bank] = 1'b1;
      chk("m_bank_full", 32'(bank_full), 32'(exp_full));
      chk("m_wr_ready",  32'(wr_ready),  32'(m_q.size() < 2));
      chk("m_rd_ready",  32'(rd_ready),  32'(m_q.size() > 0));
      chk("m_rd_len",    32'(rd_len),    (m_q.size() > 0) ? 32'(m_q[0].len) : 32'd0);
      chk("m_wr_drop",   32'(wr_drop),   32'(m_drop));
      chk("m_rd_valid",  32'(rd_valid),  32'(m_rv));
      if (m_rdk) chk("m_rd_data", 32'(rd_data), 32'(m_rd));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = 1'b0; wr_commit = 1'b0; rd_en = 1'b0; rd_release = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
  endtask

  task automatic wr(input int a, input logic [DATA_W-1:0] d, input bit cm);
    idle();
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d; wr_commit = cm;
    tick();
    idle();
  endtask

  task automatic commit();
    idle(); wr_commit = 1'b1; tick(); idle();
  endtask

  task automatic rd(input int a);
    idle(); rd_en = 1'b1; rd_addr = ADDR_W'(a); tick(); idle();
  endtask

  task automatic release_bank();
    idle(); rd_release = 1'b1; tick(); idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    chk_en = 1'b1;
    idle();
    chk("rst_bank_full", 32'(bank_full), 32'h0);
    chk("rst_wr_ready",  32'(wr_ready),  32'h1);
    chk("rst_rd_ready",  32'(rd_ready),  32'h0);
    chk("rst_rd_len",    32'(rd_len),    32'h0);
    chk("rst_rd_data",   32'(rd_data),   32'h0);

    // Basic fill / commit / read of bank0
    wr(0, 16'h0011, 0); wr(1, 16'h0022, 0); wr(2, 16'h0033, 0); wr(3, 16'h0044, 0);
    commit();
    chk("b0_full",  32'(bank_full), 32'h1);
    chk("b0_rdy",   32'(rd_ready),  32'h1);
    chk("b0_len",   32'(rd_len),    32'd4);
    rd(2);
    chk("b0_rd2",   32'(rd_data),   32'h0033);
    chk("b0_rv",    32'(rd_valid),  32'h1);

    // Read + release of bank0 while bank1 is being written
    idle();
    rd_en = 1'b1; rd_addr = 3'd1; rd_release = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h1111;
    tick(); idle();
    chk("rel_rd1",  32'(rd_data),   32'h0022);
    chk("rel_full", 32'(bank_full), 32'h0);
    chk("rel_rdy",  32'(rd_ready),  32'h0);
    wr(5, 16'h5555, 0);
    commit();
    chk("b1_full",  32'(bank_full), 32'h2);
    chk("b1_len",   32'(rd_len),    32'd2);
    rd(1);
    chk("b1_rd1",   32'(rd_data),   32'h1111);

    // Write+commit in one cycle, then overflow drop with both banks full
    wr(0, 16'h0A0A, 0);
    wr(7, 16'h00AA, 1);
    chk("both_full", 32'(bank_full), 32'h3);
    chk("both_wrdy", 32'(wr_ready),  32'h0);
    wr(5, 16'hBEEF, 0);
    chk("drop_1",    32'(wr_drop),   32'h1);
    chk("drop_wrdy", 32'(wr_ready),  32'h0);
    tick();
    chk("drop_0",    32'(wr_drop),   32'h0);
    rd(5);
    chk("keep_b1_5", 32'(rd_data),   32'h5555);
    release_bank();
    chk("b0b_full",  32'(bank_full), 32'h1);
    chk("b0b_len",   32'(rd_len),    32'd2);
    rd(7);
    chk("b0b_rd7",   32'(rd_data),   32'h00AA);
    release_bank();
    chk("empty",     32'(bank_full), 32'h0);

    // Same address written three times into bank1
    wr(3, 16'h0301, 0); wr(3, 16'h0302, 0); wr(3, 16'h0303, 0);
    commit();
    chk("rep_len",   32'(rd_len),    32'd3);
    rd(3);
    chk("rep_rd3",   32'(rd_data),   32'h0303);

    // Overfill bank0: count saturates at DEPTH
    for (int i = 0; i < DEPTH + 2; i++) wr(i % DEPTH, DATA_W'(16'h0700 + i), 0);
    commit();
    release_bank();
    chk("sat_len",   32'(rd_len),    32'(DEPTH));

    // Reset mid-fill with bank0 full and a read in flight
    wr(0, 16'h0C0C, 0);
    rd(DEPTH - 1);
    idle();
    rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hDEAD; rd_en = 1'b1;
    tick(); idle();
    chk("mrst_full", 32'(bank_full), 32'h0);
    chk("mrst_rv",   32'(rd_valid),  32'h0);
    chk("mrst_rd",   32'(rd_data),   32'h0);
    chk("mrst_wrdy", 32'(wr_ready),  32'h1);
    chk("mrst_rrdy", 32'(rd_ready),  32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      wr_en      = ($urandom_range(0, 99) < 60);
      wr_addr    = ADDR_W'($urandom_range(0, DEPTH - 1));
      wr_data    = DATA_W'($urandom);
      wr_commit  = ($urandom_range(0, 99) < 10);
      rd_en      = ($urandom_range(0, 99) < 50);
      rd_addr    = ADDR_W'($urandom_range(0, DEPTH - 1));
      rd_release = ($urandom_range(0, 99) < 10);
      tick();
    end
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
